// File: rtl/mem_line_responder.sv
// Line-fill responder: round-robin arbitration between an instruction-fill channel and a
// data fill/writeback channel, one request in flight, serviced after a fixed latency.
module mem_line_responder #(
  parameter int unsigned ADDR_W  = 36,
  parameter int unsigned LINE_W  = 128,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_req_valid,
  output logic              i_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              i_resp_valid,
  input  logic              i_resp_ready,
  output logic [LINE_W-1:0] i_resp_data,
  input  logic              d_req_valid,
  output logic              d_req_ready,
  input  logic              d_req_we,
  input  logic [ADDR_W-1:0] d_req_addr,
  input  logic [LINE_W-1:0] d_req_wdata,
  output logic              d_resp_valid,
  input  logic              d_resp_ready,
  output logic [LINE_W-1:0] d_resp_data,
  output logic              busy,
  output logic              err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic RR_I = 1'b0;
  localparam logic RR_D = 1'b1;

  logic [1:0]        r_state;
  logic              r_rr;
  logic              r_src;
  logic              r_we;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic [LINE_W-1:0] r_wdata;
  logic              r_i_valid;
  logic              r_d_valid;
  logic [LINE_W-1:0] r_i_data;
  logic [LINE_W-1:0] r_d_data;
  logic [LINE_W-1:0] r_mem [DEPTH];

  logic              w_idle;
  logic              w_i_acc;
  logic              w_d_acc;
  logic              w_acc;
  logic [ADDR_W-1:0] w_addr;
  logic              w_hi_bits;
  logic              w_fire;
  logic              w_resp_done;
  logic [LINE_W-1:0] w_line;
  logic              w_unused_lo;

  // Readies are forced low while reset is asserted, not just once the state settles.
  assign w_idle      = rst_n && (r_state == ST_IDLE);
  assign i_req_ready = w_idle && (!d_req_valid || r_rr == RR_I);
  assign d_req_ready = w_idle && (!i_req_valid || r_rr == RR_D);

  assign w_i_acc     = i_req_valid && i_req_ready;
  assign w_d_acc     = d_req_valid && d_req_ready;
  assign w_acc       = w_i_acc || w_d_acc;
  assign w_addr      = w_d_acc ? d_req_addr : i_req_addr;
  assign w_hi_bits   = |w_addr[ADDR_W-1:IDX_W+4];
  assign w_unused_lo = ^w_addr[3:0];

  assign w_fire      = (r_state == ST_WAIT) && (r_cnt == '0);
  assign w_resp_done = (r_state == ST_RESP) && (r_src ? d_resp_ready : i_resp_ready);
  assign w_line      = r_we ? r_wdata : r_mem[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_rr      <= RR_I;
      r_src     <= RR_I;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_cnt     <= '0;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_i_valid <= 1'b0;
      r_d_valid <= 1'b0;
      r_i_data  <= '0;
      r_d_data  <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_acc) begin
            r_src   <= w_d_acc ? RR_D : RR_I;
            r_rr    <= w_d_acc ? RR_I : RR_D;
            r_we    <= w_d_acc && d_req_we;
            r_wdata <= d_req_wdata;
            r_idx   <= w_addr[IDX_W+3:4];
            r_cnt   <= CNT_LOAD;
            r_state <= ST_WAIT;
            if (w_hi_bits) r_err <= 1'b1;
          end
        end
        ST_WAIT: begin
          if (w_fire) begin
            if (r_src == RR_D) begin
              r_d_data  <= w_line;
              r_d_valid <= 1'b1;
            end else begin
              r_i_data  <= w_line;
              r_i_valid <= 1'b1;
            end
            r_state <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (w_resp_done) begin
            r_i_valid <= 1'b0;
            r_d_valid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Backing array is deliberately left out of reset so lines survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_fire && r_we) r_mem[r_idx] <= r_wdata;
  end

  assign i_resp_valid = r_i_valid;
  assign i_resp_data  = r_i_data;
  assign d_resp_valid = r_d_valid;
  assign d_resp_data  = r_d_data;
  assign busy         = (r_state != ST_IDLE);
  assign err          = r_err;

endmodule

// File: tb/tb_mem_line_responder.sv
// Scoreboard bench: a negedge monitor predicts each accepted request from a line-level memory
// model and checks responses, readies, busy and err against it.
module tb_mem_line_responder;
  localparam int unsigned ADDR_W  = 36;
  localparam int unsigned LINE_W  = 128;
  localparam int unsigned DEPTH   = 1024;
  localparam int unsigned LATENCY = 4;
  localparam int unsigned NSET    = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_req_valid = 1'b0;
  logic              i_req_ready;
  logic [ADDR_W-1:0] i_req_addr = '0;
  logic              i_resp_valid;
  logic              i_resp_ready = 1'b1;
  logic [LINE_W-1:0] i_resp_data;
  logic              d_req_valid = 1'b0;
  logic              d_req_ready;
  logic              d_req_we = 1'b0;
  logic [ADDR_W-1:0] d_req_addr = '0;
  logic [LINE_W-1:0] d_req_wdata = '0;
  logic              d_resp_valid;
  logic              d_resp_ready = 1'b1;
  logic [LINE_W-1:0] d_resp_data;
  logic              busy;
  logic              err;

  mem_line_responder #(
    .ADDR_W (ADDR_W),
    .LINE_W (LINE_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_req_valid (i_req_valid),
    .i_req_ready (i_req_ready),
    .i_req_addr  (i_req_addr),
    .i_resp_valid(i_resp_valid),
    .i_resp_ready(i_resp_ready),
    .i_resp_data (i_resp_data),
    .d_req_valid (d_req_valid),
    .d_req_ready (d_req_ready),
    .d_req_we    (d_req_we),
    .d_req_addr  (d_req_addr),
    .d_req_wdata (d_req_wdata),
    .d_resp_valid(d_resp_valid),
    .d_resp_ready(d_resp_ready),
    .d_resp_data (d_resp_data),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: memory as an associative array of lines, responses as per-channel queues.
  logic [LINE_W-1:0] m_mem [int];
  logic [LINE_W-1:0] q_i[$];
  logic [LINE_W-1:0] q_d[$];
  int                grants[$];
  bit                m_busy = 1'b0;
  bit                pref_i = 1'b1;
  bit                m_err = 1'b0;
  bit                pv_i = 1'b0;
  bit                pv_d = 1'b0;
  bit                exp_ir;
  bit                exp_dr;
  int unsigned       acc_i = 0;
  int unsigned       acc_d = 0;
  bit                rnd_rdy = 1'b0;
  bit                hold_d = 1'b0;

  task automatic check(input string name, input logic [LINE_W-1:0] act,
                       input logic [LINE_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int line_of(input logic [ADDR_W-1:0] a);
    longint unsigned x = 64'(a);
    return int'((x / 16) % DEPTH);
  endfunction

  function automatic bit out_of_range(input logic [ADDR_W-1:0] a);
    longint unsigned x = 64'(a);
    return (x / 16) >= DEPTH;
  endfunction

  function automatic logic [LINE_W-1:0] model_read(input logic [ADDR_W-1:0] a);
    int k = line_of(a);
    if (m_mem.exists(k)) return m_mem[k];
    return 'x;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_i_req_ready", i_req_ready, 0);
      check("rst_d_req_ready", d_req_ready, 0);
      check("rst_i_resp_valid", i_resp_valid, 0);
      check("rst_d_resp_valid", d_resp_valid, 0);
      check("rst_i_resp_data", i_resp_data, 0);
      check("rst_d_resp_data", d_resp_data, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err, 0);
      q_i.delete();
      q_d.delete();
      m_busy = 1'b0;
      pref_i = 1'b1;
      m_err  = 1'b0;
      pv_i   = 1'b0;
      pv_d   = 1'b0;
    end else begin
      exp_ir = !m_busy && (!d_req_valid || pref_i);
      exp_dr = !m_busy && (!i_req_valid || !pref_i);
      check("i_req_ready", i_req_ready, exp_ir);
      check("d_req_ready", d_req_ready, exp_dr);
      check("busy", busy, m_busy);
      check("err", err, m_err);
      if (i_resp_valid) begin
        if (q_i.size() == 0) check("i_resp_unexpected", i_resp_valid, 0);
        else begin
          check("i_resp_data", i_resp_data, q_i[0]);
          if (!pv_i) check("i_latency", cyc - acc_i, LATENCY);
          if (i_resp_ready) begin
            void'(q_i.pop_front());
            m_busy = 1'b0;
          end
        end
      end
      pv_i = i_resp_valid;
      if (d_resp_valid) begin
        if (q_d.size() == 0) check("d_resp_unexpected", d_resp_valid, 0);
        else begin
          check("d_resp_data", d_resp_data, q_d[0]);
          if (!pv_d) check("d_latency", cyc - acc_d, LATENCY);
          if (d_resp_ready) begin
            void'(q_d.pop_front());
            m_busy = 1'b0;
          end
        end
      end
      pv_d = d_resp_valid;
      if (i_req_valid && i_req_ready) begin
        q_i.push_back(model_read(i_req_addr));
        if (out_of_range(i_req_addr)) m_err = 1'b1;
        m_busy = 1'b1;
        pref_i = 1'b0;
        acc_i  = cyc + 1;
        grants.push_back(0);
      end
      if (d_req_valid && d_req_ready) begin
        if (d_req_we) begin
          m_mem[line_of(d_req_addr)] = d_req_wdata;
          q_d.push_back(d_req_wdata);
        end else begin
          q_d.push_back(model_read(d_req_addr));
        end
        if (out_of_range(d_req_addr)) m_err = 1'b1;
        m_busy = 1'b1;
        pref_i = 1'b1;
        acc_d  = cyc + 1;
        grants.push_back(1);
      end
    end
  end

  always @(posedge clk) begin
    #2;
    i_resp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    d_resp_ready = hold_d ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
  end

  task automatic i_req(input logic [ADDR_W-1:0] a);
    bit done = 1'b0;
    i_req_valid = 1'b1;
    i_req_addr  = a;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (i_req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("i_req_timeout", 0, 1);
    i_req_valid = 1'b0;
  endtask

  task automatic d_req(input logic [ADDR_W-1:0] a, input logic we, input logic [LINE_W-1:0] wd);
    bit done = 1'b0;
    d_req_valid = 1'b1;
    d_req_addr  = a;
    d_req_we    = we;
    d_req_wdata = wd;
    for (int n = 0; n < 500 && !done; n++) begin
      @(negedge clk);
      if (d_req_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!done) check("d_req_timeout", 0, 1);
    d_req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge clk);
      if (!busy && q_i.size() == 0 && q_d.size() == 0) done = 1'b1;
    end
    if (!done) check("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    longint unsigned idx = longint'($urandom_range(0, NSET - 1));
    longint unsigned lo  = longint'($urandom_range(0, 15));
    longint unsigned hi  = ($urandom_range(0, 7) == 0) ? longint'($urandom_range(1, 3)) : 0;
    return ADDR_W'(hi * DEPTH * 16 + idx * 16 + lo);
  endfunction

  function automatic logic [LINE_W-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #2;
    check("post_rst_i_req_ready", i_req_ready, 1);
    check("post_rst_d_req_ready", d_req_ready, 0);
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(posedge clk);
    #1;

    // Writeback then instruction fill of the same line.
    d_req(36'h40, 1'b1, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D);
    wait_idle();
    i_req(36'h4C);
    wait_idle();

    for (int k = 0; k < int'(NSET); k++) begin
      d_req(ADDR_W'(k * 16), 1'b1, rand_line());
      wait_idle();
    end

    // Both channels requesting at once: expect grants I, D, I.
    grants.delete();
    fork
      begin
        i_req(36'h20);
        i_req(36'h30);
      end
      d_req(36'h70, 1'b0, '0);
    join
    wait_idle();
    check("grant_count", grants.size(), 3);
    if (grants.size() == 3) begin
      check("grant0", grants[0], 0);
      check("grant1", grants[1], 1);
      check("grant2", grants[2], 0);
    end

    // Backpressure on the data response.
    hold_d = 1'b1;
    d_req(36'h40, 1'b0, '0);
    for (int n = 0; n < 100 && !d_resp_valid; n++) @(posedge clk);
    check("bp_resp_seen", d_resp_valid, 1);
    repeat (10) @(posedge clk);
    #1 hold_d = 1'b0;
    wait_idle();

    // Index wrap with out-of-range high bits.
    d_req(36'h50, 1'b1, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210);
    wait_idle();
    i_req(ADDR_W'(DEPTH * 16 + 'h50));
    wait_idle();
    repeat (5) @(posedge clk);
    #1;

    // Reset two cycles after an accept drops the request; array contents survive.
    i_req(36'h60);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    i_req(36'h64);
    wait_idle();

    rnd_rdy = 1'b1;
    fork
      for (int t = 0; t < 60; t++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        i_req(rand_addr());
      end
      for (int t = 0; t < 60; t++) begin
        repeat ($urandom_range(0, 3)) @(posedge clk);
        #1;
        d_req(rand_addr(), 1'($urandom_range(0, 1)), rand_line());
      end
    join
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
# mem_line_responder

Memory-side responder for the processor's cache line-fill interface: it serves instruction-cache fills and data-cache fills and writebacks. Two independent valid/ready request channels are arbitrated round-robin, and each accepted request is serviced against an internal line-addressed backing array after a fixed, parameterised latency. The response returns on the matching channel. The block sits below the fetch and memory stages, standing in for the host memory path in the ASE simulation environment.

## Interface
- `ADDR_W`, 36: byte-address width, same as the processor PC and scalar width.
- `LINE_W`, 128: line width in bits (4 x 32-bit words, one vector register).
- `DEPTH`, 1024: number of lines in the backing array; power of two.
- `LATENCY`, 4: cycles from request accept to response valid; must be ≥ 1.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_req_valid`  in  1  instruction-fill request valid.
- `i_req_ready`  out  1  instruction request accepted this cycle when high together with `i_req_valid`.
- `i_req_addr`  in  ADDR_W  instruction-fill byte address.
- `i_resp_valid`  out  1  instruction response valid.
- `i_resp_ready`  in  1  consumer takes the instruction response.
- `i_resp_data`  out  LINE_W  instruction line data.
- `d_req_valid`  in  1  data request valid.
- `d_req_ready`  out  1  data request accepted this cycle when high together with `d_req_valid`.
- `d_req_we`  in  1  1 = line writeback, 0 = line fill.
- `d_req_addr`  in  ADDR_W  data byte address.
- `d_req_wdata`  in  LINE_W  writeback line.
- `d_resp_valid`  out  1  data response valid; for both fills and writeback acks.
- `d_resp_ready`  in  1  consumer takes the data response.
- `d_resp_data`  out  LINE_W  fill data, or an echo of the written line on writeback.
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky address-range error flag.

## Operation
- Line index is `addr[log2(DEPTH)+3:4]`.
  - `addr[3:0]` is ignored.
  - Bits above the index wrap: they are not used for indexing.
- FSM has three states: IDLE, WAIT, RESP.
- In IDLE, arbitration and ready are combinational:
  - `i_req_ready = IDLE && (!d_req_valid || rr == I)`.
  - `d_req_ready = IDLE && (!i_req_valid || rr == D)`.
  - The two readies are never both high while both valids are high.
- On an accepted handshake (valid && ready):
  - Latch address, `we`, `wdata` and source.
  - Load the counter with `LATENCY-1` and go to WAIT.
  - Set `rr` to the other channel.
- In WAIT, the counter decrements each cycle. When it is 0:
  - Read: the array line is registered into the source's resp_data.
  - Write: the array line is written, and resp_data takes `wdata`.
  - Go to RESP with the source's resp_valid set.
- In RESP, the source's resp_valid and resp_data hold stable until its resp_ready is high at a clock edge.
  - That edge clears resp_valid and returns the FSM to IDLE.
  - The other channel's resp_valid stays 0 throughout.
- `err` is set when an accepted request has a nonzero address bit above the index field.
  - The request is still serviced using the wrapped index.
  - `err` is cleared only by reset.
- Reset (asserted at any time, including mid-WAIT or mid-RESP):
  - State goes to IDLE, `rr` to I, the counter to 0, and both resp_valid to 0.
  - Both resp_data go to 0; `busy` and `err` go to 0.
  - A pending request or response is dropped.
  - Array contents are not reset.
- Reset value of `i_req_ready`/`d_req_ready`: 0 during reset. After reset they follow the IDLE arbitration equations.

## Timing
- Accept at edge N gives resp_valid high after edge N+LATENCY.
  - Data for a fill is valid in the same cycle as resp_valid.
  - With `LATENCY`=1, WAIT lasts one cycle.
- A write is visible to a read accepted at any later edge.
- Responses are single-beat.
- Throughput is one outstanding request.
  - A response handshake at edge M returns the FSM to IDLE.
  - The next request can be accepted at edge M+1 at the earliest.
  - The minimum request-to-request spacing is LATENCY+2 cycles when resp_ready is held high.
- If both channels are valid at the same IDLE edge, the channel indicated by `rr` wins. The loser's valid must hold; it is granted next.
- Request inputs are ignored outside IDLE. Resp_ready is ignored while its resp_valid is 0.
- `busy` rises the cycle after accept and falls the cycle after the response handshake.

## Test plan
- **Reset values:** apply reset with both valids high → all outputs 0. After release, `i_req_ready`=1 and `d_req_ready`=0 (`rr`=I).
- **Write then read:**
  - Data writeback of 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D to addr 0x40 → `d_resp_valid` 4 cycles after accept, with echoed data.
  - Instruction fill of addr 0x4C → identical line returned, `err`=0.
- **Simultaneous requests:** both valid at the first IDLE edge → I served first, then D, then I again with both held valid. The grant order is I, D, I.
- **Backpressure:** hold `d_resp_ready`=0 for 10 cycles after `d_resp_valid` → data stable and `busy`=1 throughout. The handshake on release gives IDLE on the next cycle, and new accepts occur no earlier.
- **Wrap and err:** write line A to index 5, then read addr `(DEPTH*16)+0x50` → line A returned, and `err` becomes 1 and stays 1 until reset.
- **Reset mid-operation:** assert `rst_n`=0 two cycles after an accept → no response is ever produced. After release, a new fill of a previously written line returns the pre-reset written data.
